// File: rtl/mem_io_arbiter_pkg.sv
// mem_io_arbiter_pkg: shared widths, FSM/port enums and I/O address map for the CPU memory system.
package mem_io_arbiter_pkg;
  localparam int ADDR_W = 16;
  localparam int DATA_W = 16;
  localparam logic [15:0] SW_ADDR = 16'hFFFE;
  localparam logic [15:0] LED_ADDR = 16'hFFFF;
  typedef enum logic [1:0] {IDLE, BUSY_F, BUSY_D} state_e;
  typedef enum logic {FETCH, DATA} port_e;
endpackage

// File: rtl/mem_io_arbiter_if.sv
// mem_io_arbiter_if: fetch port, data port and RAM port bundled between CPU, arbiter and RAM.
interface mem_io_arbiter_if #(
  parameter int ADDR_W = mem_io_arbiter_pkg::ADDR_W,
  parameter int DATA_W = mem_io_arbiter_pkg::DATA_W
);
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic [DATA_W-1:0] if_rdata;
  logic              if_valid;
  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic [DATA_W-1:0] d_rdata;
  logic              d_valid;
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  modport slave (
    input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    output if_rdata, if_valid, d_rdata, d_valid, mem_en, mem_we, mem_addr, mem_wdata
  );
  modport master (
    output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    input  if_rdata, if_valid, d_rdata, d_valid, mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_io_arbiter_sync2.sv
// sync2: parameterized-width two-flop synchronizer for asynchronous inputs.
module sync2 #(
  parameter int W = 1
) (
  input  logic         clock,
  input  logic         reset,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);
  logic [W-1:0] r_s1, r_s2;
  always_ff @(posedge clock) begin
    if (reset) begin
      r_s1 <= '0;
      r_s2 <= '0;
    end else begin
      r_s1 <= i_d;
      r_s2 <= r_s1;
    end
  end
  assign o_q = r_s2;
endmodule

// File: rtl/mem_io_arbiter.sv
// mem_io_arbiter: round-robin sharing of one sync RAM between fetch and data ports,
// with switch/LED registers mapped at the top of the data address space.
module mem_io_arbiter #(
  parameter int ADDR_W = mem_io_arbiter_pkg::ADDR_W,
  parameter int DATA_W = mem_io_arbiter_pkg::DATA_W,
  parameter logic [ADDR_W-1:0] SW_ADDR = mem_io_arbiter_pkg::SW_ADDR,
  parameter logic [ADDR_W-1:0] LED_ADDR = mem_io_arbiter_pkg::LED_ADDR
) (
  input  logic                    clock,
  input  logic                    reset,
  mem_io_arbiter_if.slave         bus,
  input  logic [15:0]             switches,
  output logic [15:0]             leds
);
  import mem_io_arbiter_pkg::*;
  state_e            r_state;
  port_e             r_last;
  logic              r_io;
  logic [DATA_W-1:0] r_io_rd;
  logic [15:0]       r_leds;
  logic [15:0]       w_sw;
  logic              w_idle, w_sw_hit, w_led_hit, w_io, w_gnt_d, w_gnt_f;
  sync2 #(.W(16)) u_sync (.clock(clock), .reset(reset), .i_d(switches), .o_q(w_sw));
  assign w_idle    = r_state == IDLE;
  assign w_sw_hit  = bus.d_addr == SW_ADDR;
  assign w_led_hit = bus.d_addr == LED_ADDR;
  assign w_io      = w_sw_hit | w_led_hit;
  // data wins a conflict only when fetch was the last conflict winner
  assign w_gnt_d   = w_idle & bus.d_req & (!bus.if_req | r_last == FETCH);
  assign w_gnt_f   = w_idle & bus.if_req & !w_gnt_d;
  assign bus.mem_en    = !reset & (w_gnt_f | (w_gnt_d & !w_io));
  assign bus.mem_we    = bus.mem_en & w_gnt_d & bus.d_we;
  assign bus.mem_addr  = w_gnt_d ? bus.d_addr : bus.if_addr;
  assign bus.mem_wdata = bus.d_wdata;
  assign bus.if_valid  = !reset & r_state == BUSY_F;
  assign bus.d_valid   = !reset & r_state == BUSY_D;
  assign bus.if_rdata  = bus.if_valid ? bus.mem_rdata : '0;
  assign bus.d_rdata   = bus.d_valid ? (r_io ? r_io_rd : bus.mem_rdata) : '0;
  assign leds          = r_leds;
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= IDLE;
      r_last  <= FETCH;
      r_io    <= 1'b0;
      r_io_rd <= '0;
      r_leds  <= '0;
    end else begin
      r_state <= w_gnt_d ? BUSY_D : w_gnt_f ? BUSY_F : IDLE;
      if (w_idle & bus.d_req & bus.if_req) r_last <= w_gnt_d ? DATA : FETCH;
      if (w_gnt_d) begin
        r_io    <= w_io;
        r_io_rd <= DATA_W'(w_sw_hit ? w_sw : r_leds);
        if (w_led_hit & bus.d_we) r_leds <= 16'(bus.d_wdata);
      end
    end
  end
endmodule

// File: tb/tb_mem_io_arbiter.sv
// tb_mem_io_arbiter: directed vectors with a queue scoreboard checked by a negedge monitor.
module tb_mem_io_arbiter;
  typedef struct packed {logic chk; logic [15:0] v;} exp_t;
  logic clk = 0, rst = 1;
  logic [15:0] sw = '0, leds;
  logic [15:0] ram [0:255];
  exp_t dq[$], fq[$];
  exp_t de, fe;
  byte ord[$];
  int vecs = 0, miss = 0, dcnt = 0, fcnt = 0, lat;
  logic [9:0] en_mask, v_mask;

  mem_io_arbiter_if bus ();
  mem_io_arbiter dut (.clock(clk), .reset(rst), .bus(bus), .switches(sw), .leds(leds));

  always #5 clk = ~clk;

  always @(posedge clk) if (bus.mem_en) begin
    if (bus.mem_we) ram[bus.mem_addr[7:0]] <= bus.mem_wdata;
    bus.mem_rdata <= ram[bus.mem_addr[7:0]];
  end

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      miss++;
      $display("FAIL %s: got %h expected %h at %0t", n, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (bus.if_valid || bus.d_valid) chk("one_valid", {bus.if_valid, bus.d_valid} == 2'b11, 0);
    if (bus.d_valid) begin
      dcnt++;
      ord.push_back("D");
      if (dq.size() == 0) chk("d_unexpected", 1, 0);
      else begin
        de = dq.pop_front();
        if (de.chk) chk("d_rdata", bus.d_rdata, de.v);
      end
    end
    if (bus.if_valid) begin
      fcnt++;
      ord.push_back("F");
      if (fq.size() == 0) chk("f_unexpected", 1, 0);
      else begin
        fe = fq.pop_front();
        if (fe.chk) chk("if_rdata", bus.if_rdata, fe.v);
      end
    end
  end

  task automatic acc(input bit f, input bit we, input logic [15:0] a, input logic [15:0] wd,
                     input logic [15:0] ex, input bit c, output int l);
    if (f) begin
      fq.push_back('{c, ex});
      bus.if_req = 1; bus.if_addr = a;
    end else begin
      dq.push_back('{c, ex});
      bus.d_req = 1; bus.d_we = we; bus.d_addr = a; bus.d_wdata = wd;
    end
    l = 0;
    do begin @(negedge clk); l++; end
    while (!(f ? bus.if_valid : bus.d_valid) && l < 20);
    if (!(f ? bus.if_valid : bus.d_valid)) chk("timeout", 1, 0);
    @(posedge clk); #1;
    bus.if_req = 0; bus.d_req = 0;
  endtask

  initial begin
    bus.if_req = 0; bus.if_addr = '0; bus.d_req = 0; bus.d_we = 0; bus.d_addr = '0; bus.d_wdata = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_mem_en", bus.mem_en, 0);
    chk("rst_d_rdata", bus.d_rdata, 0);
    @(posedge clk); #1 rst = 0;
    @(negedge clk);
    chk("rst_leds", leds, 0);
    chk("rst_valids", {bus.if_valid, bus.d_valid}, 0);
    @(posedge clk); #1;
    // LED write must not touch RAM
    en_mask = '0;
    fork
      acc(0, 1, 16'hFFFF, 16'h00A5, 16'h0, 0, lat);
      repeat (3) @(negedge clk) if (bus.mem_en) en_mask[0] = 1;
    join
    chk("led_lat", lat, 2);
    chk("leds_a5", leds, 16'h00A5);
    chk("led_no_mem", en_mask[0], 0);
    sw = 16'h0007;
    repeat (3) @(posedge clk); #1;
    acc(0, 0, 16'hFFFE, 16'h0, 16'h0007, 1, lat);
    sw = 16'h0005;
    repeat (3) @(posedge clk); #1;
    acc(0, 1, 16'hFFFE, 16'h9999, 16'h0, 0, lat);
    acc(0, 0, 16'hFFFE, 16'h0, 16'h0005, 1, lat);
    chk("sw_write_ignored_leds", leds, 16'h00A5);
    acc(0, 0, 16'hFFFF, 16'h0, 16'h00A5, 1, lat);
    acc(0, 1, 16'h0010, 16'h1234, 16'h0, 0, lat);
    acc(1, 0, 16'h0010, 16'h0, 16'h1234, 1, lat);
    chk("fetch_lat", lat, 2);
    acc(0, 0, 16'h0010, 16'h0, 16'h1234, 1, lat);
    acc(0, 1, 16'h0020, 16'hBEEF, 16'h0, 0, lat);
    acc(0, 1, 16'h0030, 16'hCAFE, 16'h0, 0, lat);
    // continuous conflict: D first, then alternate
    dcnt = 0; fcnt = 0; ord.delete();
    repeat (4) begin dq.push_back('{1'b1, 16'hBEEF}); fq.push_back('{1'b1, 16'hCAFE}); end
    bus.d_req = 1; bus.d_we = 0; bus.d_addr = 16'h0020; bus.if_req = 1; bus.if_addr = 16'h0030;
    repeat (16) @(posedge clk); #1;
    bus.d_req = 0; bus.if_req = 0;
    chk("conf_dcnt", dcnt, 4);
    chk("conf_fcnt", fcnt, 4);
    chk("conf_len", ord.size(), 8);
    for (int i = 0; i < ord.size(); i++) chk("conf_order", ord[i], (i % 2) ? "F" : "D");
    // fetch held for 10 cycles
    repeat (5) fq.push_back('{1'b1, 16'h1234});
    bus.if_req = 1; bus.if_addr = 16'h0010;
    en_mask = '0; v_mask = '0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      en_mask[c] = bus.mem_en;
      v_mask[c] = bus.if_valid;
      @(posedge clk);
    end
    #1 bus.if_req = 0;
    chk("hold_mem_en", en_mask, 10'h155);
    chk("hold_if_valid", v_mask, 10'h2AA);
    // reset during BUSY_D of a RAM read
    bus.d_req = 1; bus.d_we = 0; bus.d_addr = 16'h0020;
    @(negedge clk);
    chk("mid_grant_en", bus.mem_en, 1);
    @(posedge clk); #1;
    rst = 1; bus.d_req = 0;
    @(negedge clk);
    chk("mid_no_valid", bus.d_valid, 0);
    chk("mid_rst_en", bus.mem_en, 0);
    @(posedge clk); #1 rst = 0;
    @(negedge clk);
    chk("mid_leds", leds, 0);
    @(posedge clk); #1;
    acc(0, 0, 16'h0020, 16'h0, 16'hBEEF, 1, lat);
    chk("post_rst_lat", lat, 2);
    repeat (3) @(posedge clk);
    chk("dq_empty", dq.size(), 0);
    chk("fq_empty", fq.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
    $finish;
  end
endmodule

// File: doc/mem_io_arbiter.md
# mem_io_arbiter

Two-port memory and I/O arbiter between the CPU's instruction-fetch port and data port. It shares one single-port synchronous block RAM between them and maps the board switch and LED registers into the top of the data address space. It sits between the CPU core and the RAM inside the memory-mapped system top, which exposes `switches` and `leds` at board level.

## Interface
Parameters:
- `ADDR_W`, 16, address width of both ports and the RAM.
- `DATA_W`, 16, data width.
- `SW_ADDR`, 16'hFFFE, read-only switch register address.
- `LED_ADDR`, 16'hFFFF, read/write LED register address.

Ports:
- `clock` in 1: single clock; all state on rising edge.
- `reset` in 1: synchronous, active-high.
- `if_req` in 1, `if_addr` in ADDR_W: fetch request, read-only.
- `if_rdata` out DATA_W, `if_valid` out 1: fetch data and one-cycle completion pulse.
- `d_req` in 1, `d_we` in 1, `d_addr` in ADDR_W, `d_wdata` in DATA_W: data request.
- `d_rdata` out DATA_W, `d_valid` out 1: data read result and one-cycle completion or write-ack pulse.
- `mem_en` out 1, `mem_we` out 1, `mem_addr` out ADDR_W, `mem_wdata` out DATA_W: RAM port. The RAM registers its address internally.
- `mem_rdata` in DATA_W: RAM read data, valid the cycle after `mem_en`.
- `switches` in 16: asynchronous board switches.
- `leds` out 16: LED register.

## Operation
- FSM states:
  - IDLE: the arbiter may grant.
  - BUSY_F: completing a fetch.
  - BUSY_D: completing a data access.
- IDLE with no request: stay IDLE. `mem_en`=0.
- IDLE with exactly one request: grant it.
  - Drive the RAM combinationally this cycle.
  - Next state is BUSY_F or BUSY_D.
- IDLE with both requests: round-robin.
  - Grant the port not granted last.
  - `last_grant` resets to FETCH, so data wins the first conflict.
  - `last_grant` updates only on conflicts.
- BUSY_x: assert `x_valid` for exactly this cycle and return to IDLE. No grant is made in a BUSY cycle.
- Handshake:
  - A requester holds req, addr, we and wdata stable until its valid.
  - If req is still high in the cycle after valid, that is a new request.
- Address decode applies to the data port only.
  - `d_addr`==SW_ADDR: read returns the synchronized switches. Writes are ignored but still acked. `mem_en`=0.
  - `d_addr`==LED_ADDR: a write loads `leds` from `d_wdata` at the grant-cycle edge. A read returns `leds`. `mem_en`=0.
  - All other addresses go to RAM: `mem_en`=1, `mem_we`=`d_we`, `mem_addr`=`d_addr`, `mem_wdata`=`d_wdata`.
- Fetches always go to RAM, including addresses FFFE/FFFF, with `mem_we`=0.
- Read data in BUSY:
  - RAM access: `x_rdata`=`mem_rdata`.
  - I/O access: `d_rdata` comes from an I/O read register captured at the grant edge.
  - Outside the valid cycle, `rdata` is don't-care.
- Switches pass through a 2-flop synchronizer. The I/O read samples the second stage.

## Timing
- Latency is request sampled in IDLE cycle N, then valid in cycle N+1.
- Peak throughput is one access per 2 cycles.
- Under a continuous conflict, each port gets one access per 4 cycles.
- The switch change to readable value is 2 cycles, plus access latency.
- Reset values:
  - State = IDLE, `last_grant` = FETCH.
  - `if_valid`=`d_valid`=0, `leds`=0, synchronizer flops 0.
  - `mem_en`=`mem_we`=0 while reset is asserted.
  - `rdata` outputs 0.
- Reset mid-transaction: the in-flight access is dropped and no valid is issued.
  - A RAM write granted in the same cycle that reset is asserted is suppressed, because `mem_en` is forced to 0.
- A request deasserted illegally before valid is still completed. The valid pulse is issued regardless.

## Structure
- Shared CPU package: `ADDR_W` and `DATA_W` defaults, the state enum `{IDLE, BUSY_F, BUSY_D}`, the port-select enum `{FETCH, DATA}`, and the I/O address constants `SW_ADDR` and `LED_ADDR`.
- One sub-module, `sync2`: a parameterized-width 2-flop synchronizer used for `switches`.
- All other logic lives in one module. The grant decode is combinational; FSM, `last_grant`, `leds` and the I/O read register are sequential.

## Test plan
- Reset is held 2 cycles, then released.
  - Expect `leds`=0 and both valid signals 0.
  - Then `d_req` writes 16'h00A5 to LED_ADDR: `d_valid` 1 cycle later, `leds`=16'h00A5, `mem_en` never 1.
- Switches=16'h0007: `d_req` read of SW_ADDR ≥3 cycles later gives `d_rdata`=16'h0007. Switches then change to 16'h0005, and a read 3 cycles later gives 16'h0005.
- Data write 16'h1234 to address 16'h0010, then fetch from 16'h0010: `if_rdata`=16'h1234 with `if_valid` 1 cycle after the fetch grant.
- Both requests held continuously for 16 cycles: grants go D, F, D, F…, with 4 `d_valid` and 4 `if_valid` pulses total and never both valid in one cycle.
- Fetch alone with `if_req` held high for 10 cycles: `if_valid` pulses on cycles 2, 4, 6, 8, 10 and `mem_en` on cycles 1, 3, 5, 7, 9.
- Reset asserted in the BUSY_D cycle of a RAM read: no `d_valid`. After release, state is IDLE and a new data read completes normally.
